// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer slice.
//   BW_DEFAULT : default width of the count and load value.
//   ST_*       : FSM state encodings used by countdown_timer.
package countdown_pkg;

    localparam int unsigned BW_DEFAULT = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

endpackage : countdown_pkg

// File: rtl/down_counter.sv
// Loadable BW-bit decrementer that saturates at zero.
// Ports:
//   clk_i        : clock, rising edge.
//   clear_i      : synchronous clear to zero (highest priority).
//   load_i       : load load_value_i (beats hold/decrement).
//   load_value_i : value to load.
//   hold_i       : keep the current count.
//   count_o      : registered count.
//   zero_o       : high when the registered count is zero.
module down_counter
    import countdown_pkg::*;
#(
    parameter int unsigned BW = BW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic [BW-1:0] load_value_i,
    input  logic          hold_i,
    output logic [BW-1:0] count_o,
    output logic          zero_o
);

    logic [BW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_value_i;
        end else if (!hold_i && (count_q != '0)) begin
            count_d = count_q - BW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        count_q <= count_d;
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule : down_counter

// File: rtl/countdown_timer.sv
// Countdown timer with load handshake, pause, auto-reload and abort.
// Ports:
//   clk_i        : clock, rising edge.
//   rstSync_i    : synchronous active-high reset.
//   load_valid_i : load request; accepted when load_ready_o is high.
//   load_value_i : start value, sampled on the handshake.
//   load_ready_o : high only in IDLE and not in reset.
//   en_i         : decrement enable; low pauses the countdown.
//   autoReload_i : on expiry, restart from the stored load value.
//   abort_i      : cancel a running or paused countdown.
//   count_o      : registered current count.
//   busy_o       : registered, high in RUN or PAUSE.
//   done_o       : registered one-cycle pulse when the count first shows 0.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned BW = BW_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rstSync_i,
    input  logic          load_valid_i,
    input  logic [BW-1:0] load_value_i,
    output logic          load_ready_o,
    input  logic          en_i,
    input  logic          autoReload_i,
    input  logic          abort_i,
    output logic [BW-1:0] count_o,
    output logic          busy_o,
    output logic          done_o
);

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] reload_q, reload_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic          ctr_clear, ctr_load, ctr_hold, ctr_zero;
    logic [BW-1:0] ctr_value;
    logic          handshake;

    assign load_ready_o = (state_q == ST_IDLE) && !rstSync_i;
    assign handshake    = load_valid_i && load_ready_o;

    // Expiry is decided on the edge that takes the count from 1 to 0, so done_o
    // rises together with the zero count. With auto-reload the FSM stays in RUN
    // showing 0 for one cycle and reloads on the following edge (period N+1).
    // PAUSE with en_i high behaves like RUN so no cycle is lost on resume.
    always_comb begin
        state_d   = state_q;
        reload_d  = reload_q;
        done_d    = 1'b0;
        ctr_clear = rstSync_i;
        ctr_load  = 1'b0;
        ctr_value = reload_q;
        ctr_hold  = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    reload_d  = load_value_i;
                    ctr_load  = 1'b1;
                    ctr_value = load_value_i;
                    if (load_value_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN, ST_PAUSE: begin
                if (abort_i) begin
                    state_d   = ST_IDLE;
                    ctr_clear = 1'b1;
                end else if (!en_i) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_RUN;
                    if (ctr_zero) begin
                        ctr_load = 1'b1;
                    end else begin
                        ctr_hold = 1'b0;
                        if (count_o == BW'(1)) begin
                            done_d = 1'b1;
                            if (!autoReload_i) begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                ctr_clear = 1'b1;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rstSync_i) begin
            state_q  <= ST_IDLE;
            reload_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    down_counter #(
        .BW(BW)
    ) u_down_counter (
        .clk_i        (clk_i),
        .clear_i      (ctr_clear),
        .load_i       (ctr_load),
        .load_value_i (ctr_value),
        .hold_i       (ctr_hold),
        .count_o      (count_o),
        .zero_o       (ctr_zero)
    );

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule : countdown_timer

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter BW SHALL be provided: default 4, the width of the count and load value.
REQ-002 Clock port clk_i SHALL be an input of width 1: the single clock; all state updates on its rising edge.
REQ-003 Reset port rstSync_i SHALL be an input of width 1: synchronous, active-high reset.
REQ-004 load_valid_i SHALL be an input of width 1: the load request.
REQ-005 load_value_i SHALL be an input of width BW: the start value, sampled on handshake.
REQ-006 load_ready_o SHALL be an output of width 1: the timer accepts a load.
REQ-007 en_i SHALL be an input of width 1: decrement enable, low means pause.
REQ-008 autoReload_i SHALL be an input of width 1: reload the stored value on expiry.
REQ-009 abort_i SHALL be an input of width 1: cancel the current countdown.
REQ-010 count_o SHALL be an output of width BW: the registered current count.
REQ-011 busy_o SHALL be an output of width 1: high in RUN or PAUSE.
REQ-012 done_o SHALL be an output of width 1: a one-cycle expiry pulse.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and PAUSE.
REQ-014 load_ready_o SHALL be high only in IDLE, and low while rstSync_i is high.
REQ-015 A handshake (load_valid_i & load_ready_o at an edge) SHALL load count_o and the internal reload register with load_value_i in the next cycle and enter RUN.
REQ-016 A handshake with load_value_i=0 SHALL stay in IDLE, hold count_o=0 and pulse done_o in the next cycle.
REQ-017 In RUN with en_i=1, count_o SHALL decrement by exactly 1 per cycle with no wrap below 0.
REQ-018 In RUN with en_i=0, the FSM SHALL move to PAUSE, count_o SHALL hold and done_o SHALL stay 0.
REQ-019 In PAUSE with en_i=1, the FSM SHALL return to RUN and resume decrementing from the held value.
REQ-020 done_o SHALL be high for exactly the cycle in which count_o first shows 0, registered together with count_o.
REQ-021 On the edge at which count_o=0 is shown, autoReload_i=1 SHALL reload count_o from the reload register and stay in RUN, giving a period of N+1 cycles.
REQ-022 On that edge, autoReload_i=0 SHALL enter IDLE with count_o held at 0.
REQ-023 abort_i in RUN or PAUSE SHALL enter IDLE and clear count_o to 0 at the next edge without a done_o pulse.
REQ-024 abort_i SHALL win over a simultaneous expiry, so that no done_o pulse occurs.
REQ-025 abort_i SHALL have no effect in IDLE, and a simultaneous handshake SHALL proceed.
REQ-026 load_valid_i SHALL be ignored outside IDLE, and load_value_i changes after the handshake SHALL have no effect.

Reset
REQ-027 rstSync_i high at an edge SHALL override all other inputs and give state IDLE, count_o=0, reload register 0, done_o=0 and busy_o=0.
REQ-028 Reset mid-countdown SHALL abandon the countdown without a done_o pulse.
REQ-029 load_ready_o SHALL be 1 in the first cycle after rstSync_i deasserts.

Structure
REQ-030 The state encodings IDLE/RUN/PAUSE and the default BW SHALL live in the shared package countdown_pkg.
REQ-031 The datapath SHALL be one sub-module, down_counter: a loadable BW-bit decrementer with a synchronous clear, a hold input and a zero flag.
REQ-032 All outputs except load_ready_o SHALL be driven directly from registers.

Verification (BW=4)
REQ-033 The bench SHALL hold rstSync_i for 2 cycles and check that count_o, busy_o and done_o are 0, load_ready_o is 0 during reset, and load_ready_o is 1 after.
REQ-034 The bench SHALL load 5 with en_i=1 and autoReload_i=0, and check count_o=5,4,3,2,1,0 with a single done_o pulse at 0, then IDLE with load_ready_o=1.
REQ-035 The bench SHALL load 3 with autoReload_i=1, and check count_o=3,2,1,0,3,2,1,0 with done_o every 4th cycle and busy_o always 1.
REQ-036 The bench SHALL load 6 and hold en_i=0 for 3 cycles at count 4, and check count_o stays 4 with busy_o=1, then 3,2,1,0 with one done_o pulse.
REQ-037 The bench SHALL load 15 and assert abort_i at count 9, and check count_o=0 at the next edge with no done_o pulse and load_ready_o=1.
REQ-038 The bench SHALL load 0, and check a done_o pulse in the next cycle with busy_o=0.
REQ-039 The bench SHALL load 8 and assert rstSync_i at count 2, and check all outputs are 0 at the next edge with no done_o pulse.
